// File: rtl/eth_stream_arbiter.sv
// Round-robin arbiter that drains per-channel byte FIFOs into single frames for one sender.
// Define ETH_ARB_CH_HEADER_EN to prefix each frame with a channel header byte (8'hA0 | channel).
module eth_stream_arbiter #(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 256,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_valid,
  input  logic [8*NCH-1:0] ch_data,
  output logic [NCH-1:0]   ch_rd,
  input  logic             snd_ready,
  input  logic             snd_tx_done,
  output logic             snd_valid,
  output logic [7:0]       snd_data,
  output logic             upper_ready,
  output logic [NCH-1:0]   grant,
  output logic [15:0]      frames_sent,
  output logic             timeout_err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int LW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BURST);
  localparam logic [LW-1:0] LCNT_LOAD = LW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_HDR, S_STREAM, S_LAUNCH} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic             snd_valid_q, snd_valid_d;
  logic [7:0]       snd_data_q, snd_data_d;
  logic             upper_ready_q, upper_ready_d;
  logic [15:0]      frames_q, frames_d;
  logic             tout_q, tout_d;

  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    cidx;
  int               cand;
  logic             pop;

  // First requester after the last served channel, wrapping modulo NCH.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(rr_q) + k) % NCH;
      cidx = IW'(cand);
      if (!sel_found && ch_valid[cidx]) begin
        sel_found = 1'b1;
        sel_idx   = cidx;
      end
    end
  end

  assign pop = (state_q == S_STREAM) && ch_valid[gidx_q] && (cnt_q < CNT_MAX);

  always_comb begin
    ch_rd         = '0;
    ch_rd[gidx_q] = pop;
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    lcnt_d        = lcnt_q;
    snd_valid_d   = snd_valid_q;
    snd_data_d    = snd_data_q;
    upper_ready_d = upper_ready_q;
    frames_d      = frames_q;
    tout_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snd_ready && (|ch_valid)) state_d = S_ARB;
      end
      S_ARB: begin
        if (sel_found) begin
          grant_d = NCH'(1) << sel_idx;
          gidx_d  = sel_idx;
          cnt_d   = '0;
`ifdef ETH_ARB_CH_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_STREAM;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef ETH_ARB_CH_HEADER_EN
      S_HDR: begin
        snd_valid_d = 1'b1;
        snd_data_d  = 8'hA0 | 8'(gidx_q);
        state_d     = S_STREAM;
      end
`endif
      S_STREAM: begin
        if (pop) begin
          snd_valid_d = 1'b1;
          snd_data_d  = ch_data[{gidx_q, 3'b000} +: 8];
          cnt_d       = cnt_q + CW'(1);
        end else begin
          snd_valid_d   = 1'b0;
          upper_ready_d = 1'b1;
          lcnt_d        = LCNT_LOAD;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (snd_tx_done) begin
          state_d       = S_IDLE;
          rr_d          = gidx_q;
          grant_d       = '0;
          upper_ready_d = 1'b0;
          frames_d      = frames_q + 16'd1;
        end else if (lcnt_q == '0) begin
          state_d       = S_IDLE;
          rr_d          = gidx_q;
          grant_d       = '0;
          upper_ready_d = 1'b0;
          tout_d        = 1'b1;
        end else begin
          lcnt_d = lcnt_q - LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= IW'(NCH - 1);
      gidx_q        <= '0;
      grant_q       <= '0;
      cnt_q         <= '0;
      lcnt_q        <= '0;
      snd_valid_q   <= 1'b0;
      snd_data_q    <= 8'h00;
      upper_ready_q <= 1'b0;
      frames_q      <= 16'd0;
      tout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gidx_q        <= gidx_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      lcnt_q        <= lcnt_d;
      snd_valid_q   <= snd_valid_d;
      snd_data_q    <= snd_data_d;
      upper_ready_q <= upper_ready_d;
      frames_q      <= frames_d;
      tout_q        <= tout_d;
    end
  end

  assign snd_valid   = snd_valid_q;
  assign snd_data    = snd_data_q;
  assign upper_ready = upper_ready_q;
  assign grant       = grant_q;
  assign frames_sent = frames_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Directed bench for eth_stream_arbiter with FWFT FIFO and sender models.
// Expected frames include the header byte when ETH_ARB_CH_HEADER_EN is defined.
module tb_eth_stream_arbiter;
  localparam int NCH = 4;
  localparam int MB  = 256;
  localparam int TO  = 100;
`ifdef ETH_ARB_CH_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0]   ch_valid;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]   ch_rd;
  logic             snd_ready = 1'b0;
  logic             snd_tx_done = 1'b0;
  logic             snd_valid;
  logic [7:0]       snd_data;
  logic             upper_ready;
  logic [NCH-1:0]   grant;
  logic [15:0]      frames_sent;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;

  eth_stream_arbiter #(.NCH(NCH), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_rd(ch_rd),
    .snd_ready(snd_ready), .snd_tx_done(snd_tx_done), .snd_valid(snd_valid),
    .snd_data(snd_data), .upper_ready(upper_ready), .grant(grant),
    .frames_sent(frames_sent), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // FIFO model: head byte visible while non-empty and under the per-channel pop limit.
  logic [7:0] fq [NCH][$];
  int popped [NCH];
  int lim [NCH];
  logic [NCH-1:0] rd_s;

  task automatic upd();
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i] = (fq[i].size() > 0) && (popped[i] < lim[i]);
      ch_data[8*i +: 8] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  endtask

  always @(posedge clk) begin
    rd_s = ch_rd;
    #1;
    for (int i = 0; i < NCH; i++)
      if (rd_s[i] && fq[i].size() > 0) begin
        void'(fq[i].pop_front());
        popped[i]++;
      end
    upd();
  end

  function automatic int oh2i(input logic [NCH-1:0] v);
    oh2i = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) oh2i = i;
  endfunction

  // Sender-side capture of frames and protocol watch on ch_rd.
  logic [7:0] cap_b [$];
  int flen [$];
  int fgr [$];
  int cur_len = 0;
  int cur_g = -1;
  logic prev_v = 1'b0;
  int proto_err = 0;

  always @(negedge clk) begin
    if (snd_valid === 1'b1) begin
      cap_b.push_back(snd_data);
      cur_len++;
      cur_g = oh2i(grant);
    end else if (prev_v) begin
      flen.push_back(cur_len);
      fgr.push_back(cur_g);
      cur_len = 0;
    end
    prev_v = (snd_valid === 1'b1);
    if (((ch_rd & ~ch_valid) != '0) || ($countones(ch_rd) > 1) || ((ch_rd & ~grant) != '0))
      proto_err++;
  end

  task automatic clear_cap();
    cap_b.delete();
    flen.delete();
    fgr.delete();
  endtask

  task automatic wait_up(input int budget);
    int n = 0;
    while (upper_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (upper_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_upper_ready got %b want 1 after %0d cycles", upper_ready, n);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk) snd_tx_done = 1'b1;
    @(negedge clk) snd_tx_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      fq[i].delete();
      popped[i] = 0;
      lim[i] = 1000000;
    end
    upd();
    repeat (3) @(negedge clk);
    checks++;
    if ({snd_valid, upper_ready, timeout_err, grant, ch_rd, snd_data, frames_sent} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b ur=%b te=%b g=%h rd=%h d=%h fs=%0d want all 0",
               snd_valid, upper_ready, timeout_err, grant, ch_rd, snd_data, frames_sent);
    end
    rst_n = 1'b1;
    snd_ready = 1'b1;
    pulse_done();
    checks++;
    if (frames_sent !== 16'd0 || upper_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_tx_done_ignored got fs=%0d ur=%b want fs=0 ur=0", frames_sent, upper_ready);
    end
  endtask

  task automatic test_single();
    int bad = 0;
    int l0;
    clear_cap();
    for (int j = 1; j <= 10; j++) fq[0].push_back(8'(j));
    upd();
    wait_up(60);
    l0 = (flen.size() > 0) ? flen[0] : -1;
    checks++;
    if (flen.size() != 1 || l0 != 10 + HB) begin
      errors++;
      $display("FAIL single_len got %0d frames len %0d want 1 frame len %0d", flen.size(), l0, 10 + HB);
    end
    for (int j = 0; j < 10 + HB; j++) begin
      if (j >= cap_b.size()) bad++;
      else if (HB == 1 && j == 0) begin if (cap_b[j] !== 8'hA0) bad++; end
      else if (cap_b[j] !== 8'(j + 1 - HB)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_bytes got %0d bad bytes want 0", bad);
    end
    checks++;
    if (grant !== 4'b0001 || upper_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_launch got g=%b ur=%b want g=0001 ur=1", grant, upper_ready);
    end
    pulse_done();
    checks++;
    if (frames_sent !== 16'd1 || upper_ready !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL single_done got fs=%0d ur=%b g=%b want fs=1 ur=0 g=0", frames_sent, upper_ready, grant);
    end
  endtask

  task automatic test_round_robin();
    int pos = 0;
    int bad = 0;
    int lf, gf, n;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    clear_cap();
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 300; j++) fq[i].push_back(8'(i * 64 + j));
    upd();
    for (int f = 0; f < 8; f++) begin
      wait_up(400);
      pulse_done();
    end
    for (int f = 0; f < 8; f++) begin
      lf = (f < flen.size()) ? flen[f] : -1;
      gf = (f < fgr.size()) ? fgr[f] : -1;
      n = (f < 4) ? MB : 300 - MB;
      checks++;
      if (lf != n + HB || gf != f % 4) begin
        errors++;
        $display("FAIL rr_frame%0d got ch=%0d len=%0d want ch=%0d len=%0d", f, gf, lf, f % 4, n + HB);
      end
    end
    for (int f = 0; f < 8; f++) begin
      n = (f < 4) ? MB : 300 - MB;
      if (HB == 1) begin
        if (pos >= cap_b.size() || cap_b[pos] !== (8'hA0 | 8'(f % 4))) bad++;
        pos++;
      end
      for (int j = 0; j < n; j++) begin
        if (pos >= cap_b.size() || cap_b[pos] !== 8'((f % 4) * 64 + (f / 4) * MB + j)) bad++;
        pos++;
      end
    end
    checks++;
    if (bad != 0 || pos != cap_b.size()) begin
      errors++;
      $display("FAIL rr_bytes got %0d bad, %0d captured want 0 bad, %0d captured", bad, cap_b.size(), pos);
    end
    checks++;
    if (frames_sent !== 16'd8) begin
      errors++;
      $display("FAIL rr_frames_sent got %0d want 8", frames_sent);
    end
  endtask

  task automatic test_drop();
    int bad = 0;
    int l0, g0;
    clear_cap();
    popped[2] = 0;
    lim[2] = 5;
    for (int j = 0; j < 20; j++) fq[2].push_back(8'(8'h50 + j));
    upd();
    wait_up(100);
    l0 = (flen.size() > 0) ? flen[0] : -1;
    g0 = (fgr.size() > 0) ? fgr[0] : -1;
    checks++;
    if (l0 != 5 + HB || g0 != 2) begin
      errors++;
      $display("FAIL drop_frame got ch=%0d len=%0d want ch=2 len=%0d", g0, l0, 5 + HB);
    end
    checks++;
    if (popped[2] != 5) begin
      errors++;
      $display("FAIL drop_pops got %0d want 5", popped[2]);
    end
    for (int j = 0; j < 5; j++)
      if (j + HB >= cap_b.size() || cap_b[j + HB] !== 8'(8'h50 + j)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_bytes got %0d bad want 0", bad);
    end
    pulse_done();
    fq[2].delete();
    lim[2] = 1000000;
    upd();
    checks++;
    if (frames_sent !== 16'd9) begin
      errors++;
      $display("FAIL drop_frames_sent got %0d want 9", frames_sent);
    end
  endtask

  task automatic test_timeout();
    int n = 1;
    logic [15:0] f0;
    clear_cap();
    f0 = frames_sent;
    for (int j = 0; j < 3; j++) fq[1].push_back(8'(j));
    upd();
    wait_up(100);
    while (timeout_err !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO + 1) begin
      errors++;
      $display("FAIL timeout_cycle got pulse at launch cycle %0d want %0d", n - 1, TO);
    end
    #1;
    checks++;
    if (upper_ready !== 1'b0 || grant !== '0 || frames_sent !== f0) begin
      errors++;
      $display("FAIL timeout_state got ur=%b g=%b fs=%0d want ur=0 g=0 fs=%0d", upper_ready, grant, frames_sent, f0);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width got %b want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int p;
    int l0, g0;
    for (int j = 0; j < 100; j++) fq[1].push_back(8'(j));
    upd();
    while (cur_len < 50 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (cur_len != 50) begin
      errors++;
      $display("FAIL midreset_reach got %0d bytes want 50", cur_len);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({snd_valid, upper_ready, timeout_err, grant, ch_rd, snd_data, frames_sent} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b ur=%b g=%h rd=%h d=%h fs=%0d want all 0",
               snd_valid, upper_ready, grant, ch_rd, snd_data, frames_sent);
    end
    p = popped[1];
    repeat (3) @(negedge clk);
    checks++;
    if (popped[1] != p) begin
      errors++;
      $display("FAIL midreset_no_pop got %0d pops want %0d", popped[1], p);
    end
    for (int j = 0; j < 4; j++) begin
      fq[0].push_back(8'(8'hC0 + j));
      fq[2].push_back(8'(8'hE0 + j));
    end
    upd();
    clear_cap();
    rst_n = 1'b1;
    wait_up(100);
    l0 = (flen.size() > 0) ? flen[0] : -1;
    g0 = (fgr.size() > 0) ? fgr[0] : -1;
    checks++;
    if (g0 != 0 || l0 != 4 + HB) begin
      errors++;
      $display("FAIL midreset_first_grant got ch=%0d len=%0d want ch=0 len=%0d", g0, l0, 4 + HB);
    end
    pulse_done();
    checks++;
    if (frames_sent !== 16'd1) begin
      errors++;
      $display("FAIL midreset_frames_sent got %0d want 1", frames_sent);
    end
  endtask

  initial begin
    ch_valid = '0;
    ch_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_timeout();
    test_reset_mid();
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL ch_rd_protocol got %0d bad cycles want 0", proto_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/eth_stream_arbiter.md
ETH_STREAM_ARBITER -- requirements
Module: eth_stream_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter MAX_BURST, default 256, max payload bytes per frame (1..1498).
REQ-003 Parameter TIMEOUT, default 65535, max LAUNCH cycles awaiting snd_tx_done.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ch_valid  input  NCH  per-channel first-word-fall-through FIFO non-empty.
REQ-007 ch_data  input  8*NCH  per-channel head byte; channel i at bits [8i+7:8i].
REQ-008 ch_rd  output  NCH  per-channel pop strobe, one-hot or zero.
REQ-009 snd_ready  input  1  sender idle and accepting a new frame.
REQ-010 snd_tx_done  input  1  one-cycle pulse, sender finished frame.
REQ-011 snd_valid  output  1  registered byte-valid to sender; low terminates frame buffering.
REQ-012 snd_data  output  8  registered byte to sender.
REQ-013 upper_ready  output  1  transmit permission to sender.
REQ-014 grant  output  NCH  registered one-hot channel owning current frame.
REQ-015 frames_sent  output  16  completed-frame counter, wraps 0xFFFF->0.
REQ-016 timeout_err  output  1  one-cycle pulse on LAUNCH timeout.

Function
REQ-017 States: IDLE, ARB, HDR, STREAM, LAUNCH.
REQ-018 IDLE -> ARB when snd_ready=1 and |ch_valid=1; otherwise stay.
REQ-019 ARB (1 cycle): grant = first channel with ch_valid=1 searching rr+1, rr+2, ... modulo NCH; -> HDR if header enabled, else STREAM; payload counter cleared.
REQ-020 STREAM: ch_rd[g] = ch_valid[g] AND cnt<MAX_BURST (combinational); each pop registers snd_valid<=1, snd_data<=ch_data[g], cnt+1.
REQ-021 STREAM exit when ch_rd[g]=0: next edge snd_valid<=0, -> LAUNCH; no gap cycles ever occur inside a frame.
REQ-022 LAUNCH: upper_ready=1; on snd_tx_done -> IDLE, rr<=g, grant<=0, frames_sent+1, upper_ready<=0.
REQ-023 LAUNCH cycle counter reaching TIMEOUT -> IDLE, timeout_err pulse, rr<=g, frames_sent unchanged.
REQ-024 snd_tx_done outside LAUNCH ignored; ch_valid changes on ungranted channels never affect current frame.
REQ-025 Channel deasserting ch_valid mid-STREAM ends frame early (short frame, padding is sender's job).
REQ-026 Payload per frame 1..MAX_BURST bytes; ch_rd never asserted outside STREAM.

Reset
REQ-027 Asynchronous rst_n low: state IDLE, ch_rd=0, snd_valid=0, snd_data=0, upper_ready=0, grant=0, frames_sent=0, timeout_err=0, cnt=0, rr=NCH-1 (channel 0 wins first).
REQ-028 Reset mid-frame aborts immediately; no FIFO pop after reset assertion; resumes at IDLE on release.

Configuration
REQ-029 Macro ETH_ARB_CH_HEADER_EN defined: HDR state 1 cycle, snd_valid<=1, snd_data<=8'hA0|g_index, -> STREAM; frame = header + payload (<= MAX_BURST+1 bytes).
REQ-030 Macro undefined: HDR state absent, ARB -> STREAM directly, frame = payload only.

Verification
REQ-031 Ch0 holds 10 bytes 0x01..0x0A, others empty -> snd_valid high 10 contiguous cycles (11 with header, first 0xA0), then LAUNCH; tx_done -> frames_sent=1.
REQ-032 All 4 channels with 300 bytes, MAX_BURST=256 -> grant order 0,1,2,3,0,...; each first frame exactly 256 payload bytes, remainder 44 bytes next round.
REQ-033 Ch2 ch_valid drops after 5 bytes -> frame of 5 payload bytes, snd_valid low next cycle, no pop on cycle of drop.
REQ-034 TIMEOUT=100, snd_tx_done never pulsed -> timeout_err pulse at LAUNCH cycle 100, state IDLE, frames_sent unchanged.
REQ-035 rst_n pulled low at payload byte 50 -> all outputs at reset values same cycle; after release ch0 granted first.
